// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - 4-digit FND scan controller with frame snapshot and per-slot blanking gap
// Optional leading-zero blanking: define FND_LZB_EN.
module fnd_scan_controller #(
    parameter int P_DIV   = 100000,
    parameter int P_BLANK = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic [15:0] i_bcd_value,
    output logic [1:0]  o_DigitSelect,
    output logic        o_En,
    output logic [3:0]  o_bcd,
    output logic        o_frame_start
);

    localparam int CW = (P_DIV > 2) ? $clog2(P_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(P_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((P_BLANK == 0) ? 0 : P_BLANK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam state_t SLOT_START = (P_BLANK == 0) ? S_SHOW : S_BLANK;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   snap_q, snap_d;
    logic          en_q, en_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          fs_q, fs_d;
    logic          hide;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
        if (!i_run) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                    snap_d  = i_bcd_value;
                    fs_d    = 1'b1;
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = SLOT_START;
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                        // Frame wrap: new snapshot taken together with the digit 0 slot
                        if (sel_q == 2'd3) begin
                            snap_d = i_bcd_value;
                            fs_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == S_BLANK && cnt_q == BLANK_LAST) begin
                            state_d = S_SHOW;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FND_LZB_EN
    always_comb begin
        case (sel_d)
            2'd1:    hide = (snap_d[15:4] == 12'h000);
            2'd2:    hide = (snap_d[15:8] == 8'h00);
            2'd3:    hide = (snap_d[15:12] == 4'h0);
            default: hide = 1'b0;
        endcase
    end
`else
    assign hide = 1'b0;
`endif

    // Outputs are derived from next-state values so select, nibble and enable move on one edge
    assign en_d  = (state_d == S_SHOW) && !hide;
    assign bcd_d = snap_d[{sel_d, 2'b00} +: 4];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            snap_q  <= 16'h0000;
            en_q    <= 1'b0;
            bcd_q   <= 4'h0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            en_q    <= en_d;
            bcd_q   <= bcd_d;
            fs_q    <= fs_d;
        end
    end

    assign o_DigitSelect = sel_q;
    assign o_En          = en_q;
    assign o_bcd         = bcd_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - directed bench for fnd_scan_controller (FND_LZB_EN aware)
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] val = 16'h0000;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  bcd;
    logic        fs;

    logic        run_b = 1'b0;
    logic [15:0] val_b = 16'h0000;
    logic [1:0]  sel_b;
    logic        en_b;
    logic [3:0]  bcd_b;
    logic        fs_b;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    bit lzb;

    always #5 clk = ~clk;

    fnd_scan_controller #(.P_DIV(8), .P_BLANK(2)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_run(run), .i_bcd_value(val),
        .o_DigitSelect(sel), .o_En(en), .o_bcd(bcd), .o_frame_start(fs)
    );

    fnd_scan_controller #(.P_DIV(4), .P_BLANK(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_run(run_b), .i_bcd_value(val_b),
        .o_DigitSelect(sel_b), .o_En(en_b), .o_bcd(bcd_b), .o_frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
    endtask

    task automatic tick_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic restart(input logic [15:0] v);
        rst = 1'b1;
        run = 1'b0;
        val = v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        edge_n = 0;
    endtask

    initial begin
`ifdef FND_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sel", 16'(sel), 16'h0);
        check("rst_en", 16'(en), 16'h0);
        check("rst_bcd", 16'(bcd), 16'h0);
        check("rst_fs", 16'(fs), 16'h0);

        // Basic scan and snapshot coherence
        restart(16'h1234);
        tick();
        check("e1_sel", 16'(sel), 16'h0);
        check("e1_bcd", 16'(bcd), 16'h4);
        check("e1_en", 16'(en), 16'h0);
        check("e1_fs", 16'(fs), 16'h1);
        tick();
        check("e2_en", 16'(en), 16'h0);
        check("e2_fs", 16'(fs), 16'h0);
        for (int e = 3; e <= 8; e++) begin
            tick();
            check("show0_en", 16'(en), 16'h1);
        end
        tick();
        check("e9_sel", 16'(sel), 16'h1);
        check("e9_bcd", 16'(bcd), 16'h3);
        check("e9_en", 16'(en), 16'h0);
        tick();
        val = 16'h5678;
        tick_to(17);
        check("e17_sel", 16'(sel), 16'h2);
        check("e17_bcd", 16'(bcd), 16'h2);
        tick_to(25);
        check("e25_sel", 16'(sel), 16'h3);
        check("e25_bcd", 16'(bcd), 16'h1);
        tick_to(32);
        check("e32_fs", 16'(fs), 16'h0);
        tick();
        check("e33_sel", 16'(sel), 16'h0);
        check("e33_fs", 16'(fs), 16'h1);
        check("e33_bcd", 16'(bcd), 16'h8);
        tick_to(41);
        check("e41_bcd", 16'(bcd), 16'h7);
        check("e41_sel", 16'(sel), 16'h1);

        // Async reset mid-slot
        restart(16'h1234);
        tick_to(12);
        check("ar_e12_en", 16'(en), 16'h1);
        check("ar_e12_sel", 16'(sel), 16'h1);
        rst = 1'b1;
        #1;
        check("ar_sel", 16'(sel), 16'h0);
        check("ar_en", 16'(en), 16'h0);
        check("ar_bcd", 16'(bcd), 16'h0);
        check("ar_fs", 16'(fs), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("ar_restart_sel", 16'(sel), 16'h0);
        check("ar_restart_fs", 16'(fs), 16'h1);
        check("ar_restart_bcd", 16'(bcd), 16'h4);

        // Run gating
        restart(16'h1234);
        tick_to(12);
        run = 1'b0;
        tick();
        check("rg_e13_en", 16'(en), 16'h0);
        check("rg_e13_sel", 16'(sel), 16'h0);
        check("rg_e13_fs", 16'(fs), 16'h0);
        run = 1'b1;
        tick();
        check("rg_e14_fs", 16'(fs), 16'h1);
        check("rg_e14_en", 16'(en), 16'h0);
        tick();
        check("rg_e15_en", 16'(en), 16'h0);
        tick();
        check("rg_e16_en", 16'(en), 16'h1);

        // Zero blanking on the P_DIV=4, P_BLANK=0 instance
        val_b = 16'hFA76;
        run_b = 1'b1;
        edge_n = 0;
        for (int e = 1; e <= 17; e++) begin
            logic [3:0]  nib;
            logic [15:0] v;
            int          d;
            tick();
            d = ((e - 1) / 4) % 4;
            v = 16'hFA76;
            nib = v[4*d +: 4];
            check("zb_en", 16'(en_b), 16'h1);
            check("zb_sel", 16'(sel_b), 16'(d));
            check("zb_bcd", 16'(bcd_b), 16'(nib));
            check("zb_fs", 16'(fs_b), 16'(((e - 1) % 16) == 0));
        end
        run_b = 1'b0;

        // Leading-zero blanking: 0x0042 then 0x0000 on the next frame
        restart(16'h0042);
        for (int e = 1; e <= 64; e++) begin
            int d;
            bit show;
            bit vis;
            tick();
            if (e == 1) val = 16'h0000;
            d = ((e - 1) / 8) % 4;
            show = ((e - 1) % 8) >= 2;
            if (e <= 32) vis = (d < 2) || !lzb;
            else         vis = (d == 0) || !lzb;
            check("lzb_en", 16'(en), 16'(show && vis));
            check("lzb_sel", 16'(sel), 16'(d));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
